// File: rtl/alu_decode.sv
// alu_decode: RV32 integer ALU-instruction decoder feeding a 2-entry skid buffer.
// The decoder turns R-type, I-type, LUI and AUIPC words into an ALU bundle.
// The skid buffer lets in_ready come straight from a register and still
// sustain one bundle per cycle.
// Optional feature: define ALU_DECODE_MUL_EN to decode R-type MUL
// (funct7 0000001, funct3 000) as alu_control 10. Without it, MUL is illegal.
module alu_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  alu_control,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic        use_imm,
   output logic        use_pc,
   output logic [31:0] pc_out,
   output logic        illegal
);

   localparam logic [7:0] ALU_ADD   = 8'd0;
   localparam logic [7:0] ALU_SUB   = 8'd1;
   localparam logic [7:0] ALU_AND   = 8'd2;
   localparam logic [7:0] ALU_OR    = 8'd3;
   localparam logic [7:0] ALU_XOR   = 8'd4;
   localparam logic [7:0] ALU_SLT   = 8'd5;
   localparam logic [7:0] ALU_SLTU  = 8'd6;
   localparam logic [7:0] ALU_SRA   = 8'd7;
   localparam logic [7:0] ALU_SRL   = 8'd8;
   localparam logic [7:0] ALU_SLL   = 8'd9;
`ifdef ALU_DECODE_MUL_EN
   localparam logic [7:0] ALU_MUL   = 8'd10;
`endif
   localparam logic [7:0] ALU_LUI   = 8'd11;
   localparam logic [7:0] ALU_AUIPC = 8'd12;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef struct packed {
      logic [7:0]  alu;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        use_pc;
      logic [31:0] pc_f;
      logic        ill;
   } bundle_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   logic [6:0] funct7_s;
   logic       legal_s;
   bundle_t    raw_s;
   bundle_t    dec_s;

   state_t     state_q, state_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   bundle_t    out_q, out_d;
   bundle_t    skid_q, skid_d;
   logic       accept_s;

   assign opcode_s = instr[6:0];
   assign funct3_s = instr[14:12];
   assign funct7_s = instr[31:25];
   assign accept_s = in_valid && in_ready_q;

   // Field extraction and operation selection; legal_s says whether raw_s is usable.
   always_comb begin
      raw_s      = '0;
      raw_s.pc_f = pc;
      legal_s    = 1'b0;
      case (opcode_s)
         OP_R: begin
            raw_s.rs1 = instr[19:15];
            raw_s.rs2 = instr[24:20];
            raw_s.rd  = instr[11:7];
            case (funct7_s)
               7'b0000000: begin
                  legal_s = 1'b1;
                  case (funct3_s)
                     3'b000:  raw_s.alu = ALU_ADD;
                     3'b001:  raw_s.alu = ALU_SLL;
                     3'b010:  raw_s.alu = ALU_SLT;
                     3'b011:  raw_s.alu = ALU_SLTU;
                     3'b100:  raw_s.alu = ALU_XOR;
                     3'b101:  raw_s.alu = ALU_SRL;
                     3'b110:  raw_s.alu = ALU_OR;
                     3'b111:  raw_s.alu = ALU_AND;
                     default: raw_s.alu = ALU_ADD;
                  endcase
               end
               7'b0100000: begin
                  case (funct3_s)
                     3'b000: begin
                        legal_s   = 1'b1;
                        raw_s.alu = ALU_SUB;
                     end
                     3'b101: begin
                        legal_s   = 1'b1;
                        raw_s.alu = ALU_SRA;
                     end
                     default: legal_s = 1'b0;
                  endcase
               end
               7'b0000001: begin
`ifdef ALU_DECODE_MUL_EN
                  if (funct3_s == 3'b000) begin
                     legal_s   = 1'b1;
                     raw_s.alu = ALU_MUL;
                  end else begin
                     legal_s   = 1'b0;
                  end
`else
                  legal_s = 1'b0;
`endif
               end
               default: legal_s = 1'b0;
            endcase
         end
         OP_I: begin
            raw_s.rs1     = instr[19:15];
            raw_s.rd      = instr[11:7];
            raw_s.use_imm = 1'b1;
            raw_s.imm     = {{20{instr[31]}}, instr[31:20]};
            case (funct3_s)
               3'b000: begin legal_s = 1'b1; raw_s.alu = ALU_ADD;  end
               3'b010: begin legal_s = 1'b1; raw_s.alu = ALU_SLT;  end
               3'b011: begin legal_s = 1'b1; raw_s.alu = ALU_SLTU; end
               3'b100: begin legal_s = 1'b1; raw_s.alu = ALU_XOR;  end
               3'b110: begin legal_s = 1'b1; raw_s.alu = ALU_OR;   end
               3'b111: begin legal_s = 1'b1; raw_s.alu = ALU_AND;  end
               3'b001: begin
                  raw_s.imm = {27'd0, instr[24:20]};
                  if (funct7_s == 7'b0000000) begin
                     legal_s   = 1'b1;
                     raw_s.alu = ALU_SLL;
                  end else begin
                     legal_s   = 1'b0;
                  end
               end
               3'b101: begin
                  raw_s.imm = {27'd0, instr[24:20]};
                  case (funct7_s)
                     7'b0000000: begin legal_s = 1'b1; raw_s.alu = ALU_SRL; end
                     7'b0100000: begin legal_s = 1'b1; raw_s.alu = ALU_SRA; end
                     default:    legal_s = 1'b0;
                  endcase
               end
               default: legal_s = 1'b0;
            endcase
         end
         OP_LUI: begin
            legal_s       = 1'b1;
            raw_s.alu     = ALU_LUI;
            raw_s.rd      = instr[11:7];
            raw_s.use_imm = 1'b1;
            raw_s.imm     = {12'd0, instr[31:12]};
         end
         OP_AUIPC: begin
            legal_s       = 1'b1;
            raw_s.alu     = ALU_AUIPC;
            raw_s.rd      = instr[11:7];
            raw_s.use_imm = 1'b1;
            raw_s.use_pc  = 1'b1;
            raw_s.imm     = {12'd0, instr[31:12]};
         end
         default: legal_s = 1'b0;
      endcase
   end

   // Illegal encodings collapse to a harmless ADD bundle with only pc kept.
   always_comb begin
      if (legal_s) begin
         dec_s = raw_s;
      end else begin
         dec_s      = '0;
         dec_s.pc_f = pc;
         dec_s.ill  = 1'b1;
      end
   end

   // Skid-buffer next state and data movement; in_ready/out_valid are precomputed for registering.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               state_d = ST_ONE;
               out_d   = dec_s;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && out_ready) begin
               state_d = ST_ONE;
               out_d   = dec_s;
            end else if (accept_s) begin
               state_d = ST_FULL;
               skid_d  = dec_s;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               state_d = ST_ONE;
               out_d   = skid_q;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
   end

   // State, handshake and bundle registers; reset empties the buffer at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign alu_control = out_q.alu;
   assign rs1         = out_q.rs1;
   assign rs2         = out_q.rs2;
   assign rd          = out_q.rd;
   assign imm         = out_q.imm;
   assign use_imm     = out_q.use_imm;
   assign use_pc      = out_q.use_pc;
   assign pc_out      = out_q.pc_f;
   assign illegal     = out_q.ill;

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed and randomized bench for alu_decode, with a
// queue-based reference model of the buffer and a table-driven decode model.
module tb_alu_decode;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  alu_control;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        use_imm;
   logic        use_pc;
   logic [31:0] pc_out;
   logic        illegal;

`ifdef ALU_DECODE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]  alu;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        use_pc;
      logic [31:0] pc;
      logic        ill;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   // operation code per funct3 for R-type base ops and I-type arithmetic (-1: not here)
   int r_tab [8] = '{0, 9, 5, 6, 4, 8, 3, 2};
   int i_tab [8] = '{0, -1, 5, 6, 4, -1, 3, 2};

   alu_decode dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
      .alu_control(alu_control), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .use_imm(use_imm), .use_pc(use_pc), .pc_out(pc_out), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
      exp_t e;
      int   code;
      int   f3;
      int   f7;
      int   opc;
      e    = '0;
      e.pc = p;
      code = -1;
      opc  = int'(w[6:0]);
      f3   = int'(w[14:12]);
      f7   = int'(w[31:25]);
      if (opc == 'h33) begin
         e.rs1 = w[19:15];
         e.rs2 = w[24:20];
         e.rd  = w[11:7];
         if (f7 == 0) code = r_tab[f3];
         else if (f7 == 'h20 && f3 == 0) code = 1;
         else if (f7 == 'h20 && f3 == 5) code = 7;
         else if (f7 == 1 && f3 == 0 && MUL_EN) code = 10;
      end else if (opc == 'h13) begin
         e.rs1     = w[19:15];
         e.rd      = w[11:7];
         e.use_imm = 1'b1;
         if (f3 == 1 || f3 == 5) begin
            e.imm = 32'(w[24:20]);
            if (f7 == 0) code = (f3 == 1) ? 9 : 8;
            else if (f7 == 'h20 && f3 == 5) code = 7;
         end else begin
            e.imm = {{20{w[31]}}, w[31:20]};
            code  = i_tab[f3];
         end
      end else if (opc == 'h37 || opc == 'h17) begin
         e.rd      = w[11:7];
         e.use_imm = 1'b1;
         e.use_pc  = (opc == 'h17);
         e.imm     = w >> 12;
         code      = (opc == 'h37) ? 11 : 12;
      end
      if (code < 0) begin
         e     = '0;
         e.pc  = p;
         e.ill = 1'b1;
      end else begin
         e.alu = 8'(code);
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 2)      w[6:0] = 7'h33;
      else if (k <= 5) w[6:0] = 7'h13;
      else if (k == 6) w[6:0] = 7'h37;
      else if (k == 7) w[6:0] = 7'h17;
      k = $urandom_range(0, 3);
      if (k == 0)      w[31:25] = 7'h00;
      else if (k == 1) w[31:25] = 7'h20;
      else if (k == 2) w[31:25] = 7'h01;
      return w;
   endfunction

   task automatic check_outputs();
      exp_t e;
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
         e = q[0];
         chk("alu_control", 32'(alu_control), 32'(e.alu));
         chk("rs1", 32'(rs1), 32'(e.rs1));
         chk("rs2", 32'(rs2), 32'(e.rs2));
         chk("rd", 32'(rd), 32'(e.rd));
         chk("imm", imm, e.imm);
         chk("use_imm", 32'(use_imm), 32'(e.use_imm));
         chk("use_pc", 32'(use_pc), 32'(e.use_pc));
         chk("pc_out", pc_out, e.pc);
         chk("illegal", 32'(illegal), 32'(e.ill));
      end
   endtask

   // Called at a falling edge with inputs already set: predicts the next rising edge, then checks.
   task automatic cycle();
      bit   acc;
      bit   pop;
      exp_t nb;
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() > 0);
      nb  = model(instr, pc);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(nb);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic send(input logic [31:0] w, input logic [31:0] p);
      in_valid  = 1'b1;
      instr     = w;
      pc        = p;
      out_ready = 1'b1;
      cycle();
      in_valid  = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr     = 32'd0;
      pc        = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_pc_out", pc_out, 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_alu", 32'(alu_control), 32'd0);
      reset = 1'b0;
      cycle();

      // add a0,a0,a1
      send(32'h00B50533, 32'h0000_0040);
      chk("add_alu", 32'(alu_control), 32'd0);
      chk("add_rs1", 32'(rs1), 32'd10);
      chk("add_rs2", 32'(rs2), 32'd11);
      chk("add_rd", 32'(rd), 32'd10);
      chk("add_use_imm", 32'(use_imm), 32'd0);
      // srai a0,a1,2
      send(32'h4025D513, 32'h0000_0044);
      chk("srai_alu", 32'(alu_control), 32'd7);
      chk("srai_imm", imm, 32'h0000_0002);
      chk("srai_use_imm", 32'(use_imm), 32'd1);
      // addi x1,x0,-1
      send(32'hFFF00093, 32'h0000_0048);
      chk("addi_imm", imm, 32'hFFFF_FFFF);
      // auipc t0,0x12345
      send(32'h12345297, 32'h0000_0100);
      chk("auipc_alu", 32'(alu_control), 32'd12);
      chk("auipc_imm", imm, 32'h0001_2345);
      chk("auipc_use_pc", 32'(use_pc), 32'd1);
      chk("auipc_pc_out", pc_out, 32'h0000_0100);
      // mul a0,a0,a1
      send(32'h02B50533, 32'h0000_0104);
      chk("mul_alu", 32'(alu_control), MUL_EN ? 32'd10 : 32'd0);
      chk("mul_illegal", 32'(illegal), MUL_EN ? 32'd0 : 32'd1);
      // unknown opcode
      send(32'h0000007F, 32'h0000_0108);
      chk("unk_illegal", 32'(illegal), 32'd1);
      chk("unk_rd", 32'(rd), 32'd0);
      out_ready = 1'b1;
      cycle();

      // back-pressure: three back-to-back offers, only two fit
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr = 32'h00100093; pc = 32'h200; cycle();
      chk("bp_in_ready1", 32'(in_ready), 32'd1);
      instr = 32'h00200113; pc = 32'h204; cycle();
      chk("bp_in_ready2", 32'(in_ready), 32'd0);
      instr = 32'h00300193; pc = 32'h208; cycle();
      chk("bp_hold_rd", 32'(rd), 32'd1);
      out_ready = 1'b1; cycle();
      chk("bp_second_rd", 32'(rd), 32'd2);
      chk("bp_in_ready3", 32'(in_ready), 32'd1);
      cycle();
      chk("bp_third_rd", 32'(rd), 32'd3);
      in_valid = 1'b0; cycle();
      chk("bp_drained", 32'(out_valid), 32'd0);

      // reset while FULL
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr = 32'h00100093; pc = 32'h300; cycle();
      instr = 32'h00200113; pc = 32'h304; cycle();
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rstfull_out_valid", 32'(out_valid), 32'd0);
      chk("rstfull_rd", 32'(rd), 32'd0);
      chk("rstfull_pc_out", pc_out, 32'd0);
      q.delete();
      @(negedge clk);
      reset     = 1'b0;
      out_ready = 1'b1;
      cycle();
      chk("rstfull_in_ready", 32'(in_ready), 32'd1);
      cycle();
      chk("rstfull_no_stale", 32'(out_valid), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         instr     = rand_instr();
         pc        = $urandom;
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
